// File: rtl/csi_rx_packet_ctrl.sv
// rtl/csi_rx_packet_ctrl.sv - CSI-2 receive packet header decode and payload framing
//
// Ports:
//   CLK, RST_N     word clock, asynchronous active-low reset
//   DIN[31:0]      merged lane word, byte0 = DIN[7:0] first on the wire
//   DIN_VALID      word qualifier (no backpressure)
//   PKT_START      with DIN_VALID, DIN is a packet header word
//   PH_VALID       strobe: header accepted (PH_DI/PH_WC/PH_LONG held until next)
//   ERR_ECC_CORR   strobe: single-bit header error corrected
//   ERR_ECC        strobe: uncorrectable header, packet dropped
//   ERR_ABORT      strobe: new header arrived inside a long packet
//   PL_VALID/PL_DATA/PL_KEEP/PL_LAST  payload word stream, CRC bytes masked
//   BUSY           a long packet is in progress

module csi_rx_packet_ctrl (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic [31:0] DIN,
   input  logic        DIN_VALID,
   input  logic        PKT_START,
   output logic        PH_VALID,
   output logic [7:0]  PH_DI,
   output logic [15:0] PH_WC,
   output logic        PH_LONG,
   output logic        ERR_ECC_CORR,
   output logic        ERR_ECC,
   output logic        ERR_ABORT,
   output logic        PL_VALID,
   output logic [31:0] PL_DATA,
   output logic [3:0]  PL_KEEP,
   output logic        PL_LAST,
   output logic        BUSY
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PAYLOAD = 2'd1,
      TAIL    = 2'd2
   } state_t;

   // Parity-bit membership of each of the 24 header data bits (P5..P0).
   function automatic logic [5:0] ecc_col(input logic [4:0] i);
      case (i)
         5'd0:  ecc_col = 6'h07;
         5'd1:  ecc_col = 6'h0B;
         5'd2:  ecc_col = 6'h0D;
         5'd3:  ecc_col = 6'h0E;
         5'd4:  ecc_col = 6'h13;
         5'd5:  ecc_col = 6'h15;
         5'd6:  ecc_col = 6'h16;
         5'd7:  ecc_col = 6'h19;
         5'd8:  ecc_col = 6'h1A;
         5'd9:  ecc_col = 6'h1C;
         5'd10: ecc_col = 6'h23;
         5'd11: ecc_col = 6'h25;
         5'd12: ecc_col = 6'h26;
         5'd13: ecc_col = 6'h29;
         5'd14: ecc_col = 6'h2A;
         5'd15: ecc_col = 6'h2C;
         5'd16: ecc_col = 6'h31;
         5'd17: ecc_col = 6'h32;
         5'd18: ecc_col = 6'h34;
         5'd19: ecc_col = 6'h38;
         5'd20: ecc_col = 6'h1F;
         5'd21: ecc_col = 6'h2F;
         5'd22: ecc_col = 6'h37;
         5'd23: ecc_col = 6'h3B;
         default: ecc_col = 6'h00;
      endcase
   endfunction

   state_t      state_q, state_d;
   logic [16:0] rem_q, rem_d;
   logic        ph_valid_q, ph_valid_d;
   logic [7:0]  ph_di_q, ph_di_d;
   logic [15:0] ph_wc_q, ph_wc_d;
   logic        ph_long_q, ph_long_d;
   logic        err_ecc_corr_q, err_ecc_corr_d;
   logic        err_ecc_q, err_ecc_d;
   logic        err_abort_q, err_abort_d;
   logic        pl_valid_q, pl_valid_d;
   logic [31:0] pl_data_q, pl_data_d;
   logic [3:0]  pl_keep_q, pl_keep_d;
   logic        pl_last_q, pl_last_d;

   // Header decode
   logic [5:0]  ecc_exp;
   logic [5:0]  syndrome;
   logic [23:0] flip_mask;
   logic [23:0] hdr_fixed;
   logic        hdr_ok;
   logic        hdr_corr;

   always_comb begin
      ecc_exp   = 6'h00;
      flip_mask = 24'h000000;
      for (int i = 0; i < 24; i++) begin
         if (DIN[i]) ecc_exp = ecc_exp ^ ecc_col(5'(i));
      end
      syndrome = DIN[29:24] ^ ecc_exp;
      for (int i = 0; i < 24; i++) begin
         if (syndrome == ecc_col(5'(i))) flip_mask[i] = 1'b1;
      end
      hdr_fixed = DIN[23:0] ^ flip_mask;
      // A lone syndrome bit means the flipped bit sits in the ECC byte itself.
      hdr_ok   = (DIN[31:30] == 2'b00) &&
                 ((syndrome == 6'h00) || (|flip_mask) || $onehot(syndrome));
      hdr_corr = hdr_ok && (syndrome != 6'h00);
   end

   // Payload byte accounting: rem_q counts payload plus the 2 CRC bytes.
   logic [16:0] pay_left;
   logic [2:0]  take_n;
   logic [2:0]  pay_n;
   logic [16:0] rem_after;
   logic [3:0]  keep;

   always_comb begin
      pay_left  = (rem_q > 17'd2) ? (rem_q - 17'd2) : 17'd0;
      take_n    = (rem_q >= 17'd4) ? 3'd4 : rem_q[2:0];
      pay_n     = (pay_left >= 17'd4) ? 3'd4 : pay_left[2:0];
      rem_after = rem_q - {14'd0, take_n};
      case (pay_n)
         3'd1:    keep = 4'b0001;
         3'd2:    keep = 4'b0011;
         3'd3:    keep = 4'b0111;
         3'd4:    keep = 4'b1111;
         default: keep = 4'b0000;
      endcase
   end

   always_comb begin
      state_d        = state_q;
      rem_d          = rem_q;
      ph_valid_d     = 1'b0;
      ph_di_d        = ph_di_q;
      ph_wc_d        = ph_wc_q;
      ph_long_d      = ph_long_q;
      err_ecc_corr_d = 1'b0;
      err_ecc_d      = 1'b0;
      err_abort_d    = 1'b0;
      pl_valid_d     = 1'b0;
      pl_data_d      = pl_data_q;
      pl_keep_d      = pl_keep_q;
      pl_last_d      = 1'b0;

      if (DIN_VALID && PKT_START) begin
         // A header always wins; any packet still open is abandoned.
         err_abort_d = (state_q != IDLE);
         state_d     = IDLE;
         if (hdr_ok) begin
            ph_valid_d     = 1'b1;
            err_ecc_corr_d = hdr_corr;
            ph_di_d        = hdr_fixed[7:0];
            ph_wc_d        = hdr_fixed[23:8];
            ph_long_d      = (hdr_fixed[5:4] != 2'b00);
            if (hdr_fixed[5:4] != 2'b00) begin
               state_d = PAYLOAD;
               rem_d   = {1'b0, hdr_fixed[23:8]} + 17'd2;
            end
         end else begin
            err_ecc_d = 1'b1;
         end
      end else if (DIN_VALID && (state_q != IDLE)) begin
         rem_d = rem_after;
         if (pay_n != 3'd0) begin
            pl_valid_d = 1'b1;
            pl_data_d  = DIN;
            pl_keep_d  = keep;
            pl_last_d  = (pay_left <= 17'd4);
         end
         if (rem_after == 17'd0) begin
            state_d = IDLE;
         end else if (pay_left <= {14'd0, pay_n}) begin
            state_d = TAIL;
         end else begin
            state_d = PAYLOAD;
         end
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q        <= IDLE;
         rem_q          <= 17'd0;
         ph_valid_q     <= 1'b0;
         ph_di_q        <= 8'h00;
         ph_wc_q        <= 16'h0000;
         ph_long_q      <= 1'b0;
         err_ecc_corr_q <= 1'b0;
         err_ecc_q      <= 1'b0;
         err_abort_q    <= 1'b0;
         pl_valid_q     <= 1'b0;
         pl_data_q      <= 32'h00000000;
         pl_keep_q      <= 4'h0;
         pl_last_q      <= 1'b0;
      end else begin
         state_q        <= state_d;
         rem_q          <= rem_d;
         ph_valid_q     <= ph_valid_d;
         ph_di_q        <= ph_di_d;
         ph_wc_q        <= ph_wc_d;
         ph_long_q      <= ph_long_d;
         err_ecc_corr_q <= err_ecc_corr_d;
         err_ecc_q      <= err_ecc_d;
         err_abort_q    <= err_abort_d;
         pl_valid_q     <= pl_valid_d;
         pl_data_q      <= pl_data_d;
         pl_keep_q      <= pl_keep_d;
         pl_last_q      <= pl_last_d;
      end
   end

   assign PH_VALID     = ph_valid_q;
   assign PH_DI        = ph_di_q;
   assign PH_WC        = ph_wc_q;
   assign PH_LONG      = ph_long_q;
   assign ERR_ECC_CORR = err_ecc_corr_q;
   assign ERR_ECC      = err_ecc_q;
   assign ERR_ABORT    = err_abort_q;
   assign PL_VALID     = pl_valid_q;
   assign PL_DATA      = pl_data_q;
   assign PL_KEEP      = pl_keep_q;
   assign PL_LAST      = pl_last_q;
   assign BUSY         = (state_q != IDLE);

endmodule

// File: doc/csi_rx_packet_ctrl.md
CSI_RX_PACKET_CTRL -- requirements
Module: csi_rx_packet_ctrl

Interface
REQ-001 The block SHALL have one clock and one reset: the clock is CLK, and the reset is RST_N, asynchronous and active-low.
REQ-002 The block SHALL expose the following ports (name, direction, width, meaning):
- CLK  in  1  byte-merged word clock
- RST_N  in  1  async active-low reset
- DIN  in  32  merged lane word; byte0 = DIN[7:0] is first on the wire
- DIN_VALID  in  1  DIN qualifier; there is no backpressure
- PKT_START  in  1  with DIN_VALID, marks DIN as a packet header word
- PH_VALID  out  1  one-cycle strobe: corrected header accepted
- PH_DI  out  8  data identifier (VC[7:6], DT[5:0])
- PH_WC  out  16  word count, or short-packet data field
- PH_LONG  out  1  DT >= 0x10 (long packet)
- ERR_ECC_CORR  out  1  strobe: single-bit header error corrected
- ERR_ECC  out  1  strobe: uncorrectable header, packet dropped
- ERR_ABORT  out  1  strobe: PKT_START arrived while a long packet was still in progress
- PL_VALID  out  1  payload word strobe
- PL_DATA  out  32  payload word, byte order as DIN
- PL_KEEP  out  4  byte enables; bit n covers byte n
- PL_LAST  out  1  with PL_VALID, last payload word of packet
- BUSY  out  1  state is not IDLE

Function
REQ-003 The header word SHALL be split as DI = DIN[7:0], WC = DIN[23:8], ECC = DIN[31:24].
REQ-004 Expected ECC SHALL be the CSI-2 6-bit Hamming code over DIN[23:0], with bits 7:6 forced to 0.
REQ-005 The syndrome SHALL be the received ECC[5:0] XOR the expected ECC[5:0].
REQ-006 Syndrome and received ECC[7:6] handling:
- syndrome 0 and received ECC[7:6] = 0: the header is clean.
- syndrome equal to the parity column of a data bit i (0..23): bit i is flipped, ERR_ECC_CORR is pulsed and the header is accepted.
- syndrome with exactly one bit set: the error is in the ECC field, ERR_ECC_CORR is pulsed and the header is accepted.
- any other syndrome, or ECC[7:6] != 0: ERR_ECC is pulsed and the state goes to IDLE.
REQ-007 Header outputs (PH_*, ERR_ECC*) SHALL be registered one cycle after the header word; PH_DI, PH_WC and PH_LONG hold their values until the next accepted header.
REQ-008 The FSM SHALL have the states IDLE, PAYLOAD and TAIL.
REQ-009 In IDLE, words without PKT_START SHALL be ignored.
REQ-010 A valid PKT_START word in any state SHALL be decoded as a header.
REQ-011 An accepted short packet (DT < 0x10) SHALL return to IDLE with no payload output.
REQ-012 An accepted long packet SHALL load a remaining-byte counter with WC+2 (17-bit; payload plus CRC) and enter PAYLOAD.
REQ-013 Each DIN_VALID word in PAYLOAD SHALL consume min(4, remaining) bytes.
REQ-014 Payload word output in PAYLOAD:
- PL_VALID is asserted one cycle later when the word contains at least one of the first WC payload bytes.
- PL_KEEP marks only payload bytes; CRC bytes are always masked.
- PL_LAST is asserted on the word carrying payload byte WC-1.
REQ-015 If the remaining bytes after PL_LAST are only CRC bytes, the FSM SHALL enter TAIL; TAIL consumes them without output, then goes to IDLE. Otherwise it goes to IDLE as soon as the remaining count reaches 0.
REQ-016 A long packet with WC = 0 SHALL produce no PL_VALID and consume one CRC word.
REQ-017 A long packet with WC = 65535 SHALL load 65537 into the counter without overflow.
REQ-018 Cycles with DIN_VALID low SHALL not advance any counter and SHALL emit nothing.
REQ-019 PKT_START in PAYLOAD or TAIL SHALL abort the current packet and pulse ERR_ABORT; no PL_LAST is emitted for the aborted packet. The same word is decoded as a new header in that cycle.
REQ-020 All strobes SHALL be exactly one cycle wide.
REQ-021 BUSY SHALL be 1 in PAYLOAD and TAIL.

Reset
REQ-022 While RST_N is low, the state SHALL be IDLE and every output SHALL be 0, including PH_DI, PH_WC, PL_DATA and PL_KEEP.
REQ-023 Reset asserted mid-packet SHALL discard that packet, with no PL_LAST and no error strobe.
REQ-024 After reset release, the first word accepted SHALL be a PKT_START word.

Verification
REQ-025 Short packet: header DI=0x00, WC=0x0001 with correct ECC -> PH_VALID=1, PH_LONG=0, PH_WC=0x0001; no PL_VALID; BUSY stays 0.
REQ-026 Long packet: DI=0x2B, WC=6, then 2 data words -> word1 gives KEEP=1111; word2 gives KEEP=0011 with PL_LAST=1; then IDLE with no TAIL. Repeat with WC=4: word1 gives KEEP=1111 and LAST; word2 (CRC only) is consumed silently in TAIL.
REQ-027 ECC: flip DIN[17] of a valid header -> ERR_ECC_CORR=1 and PH_WC equals the original; flip DIN[3] and DIN[17] -> ERR_ECC=1, no PH_VALID, next non-start words ignored.
REQ-028 Abort: PKT_START during PAYLOAD of a WC=100 packet -> ERR_ABORT=1, no PL_LAST for that packet, and the new header decoded in the same cycle.
REQ-029 Gaps and WC=0: DIN_VALID toggling 1/0 during payload -> identical PL output sequence; a long packet with WC=0 -> no PL_VALID, BUSY for one data word.
REQ-030 Reset: assert RST_N low for one cycle mid-PAYLOAD -> all outputs 0 immediately; a following non-start word is ignored.
